// File: rtl/counter_updown_step_if.sv
// Signal bundle for counter_updown_step. The compare_value/match pair exists
// only when COUNTER_COMPARE_EN is defined.
interface counter_updown_step_if #(
  parameter int W = 8
);
  // No handshake: every input is sampled on every rising clk edge, and the
  // outputs are valid throughout the cycle that follows that edge.
  logic         enable;
  logic         up;
  logic [W-1:0] step;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         overflow;
  logic         at_max;
  logic         at_min;
`ifdef COUNTER_COMPARE_EN
  logic [W-1:0] compare_value;
  logic         match;

  modport master (
    output enable, up, step, clear, load, load_value, compare_value,
    input  count, overflow, at_max, at_min, match
  );
  modport slave (
    input  enable, up, step, clear, load, load_value, compare_value,
    output count, overflow, at_max, at_min, match
  );
`else
  modport master (
    output enable, up, step, clear, load, load_value,
    input  count, overflow, at_max, at_min
  );
  modport slave (
    input  enable, up, step, clear, load, load_value,
    output count, overflow, at_max, at_min
  );
`endif
endinterface

// File: rtl/counter_updown_step.sv
// Up/down counter with runtime step, clear/load, wrap or saturate at 0..MAX_VALUE.
// Define COUNTER_COMPARE_EN to add the compare_value/match pulse.
module counter_updown_step #(
  parameter int MAX_VALUE   = 255,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = 0
) (
  input logic                  clk,
  input logic                  reset,
  counter_updown_step_if.slave bus
);
  localparam int W = $clog2(MAX_VALUE + 1);
  localparam logic [W-1:0] MAX_W   = W'(MAX_VALUE);
  localparam logic [W-1:0] RESET_W = W'(RESET_VALUE);
  localparam logic [W:0]   MAX_X   = (W+1)'(MAX_VALUE);
  localparam logic [W:0]   MOD_X   = (W+1)'(MAX_VALUE + 1);

  if (MAX_VALUE < 1) begin : g_max_check
    $error("counter_updown_step: MAX_VALUE must be at least 1");
  end
  if ((RESET_VALUE < 0) || (RESET_VALUE > MAX_VALUE)) begin : g_reset_check
    $error("counter_updown_step: RESET_VALUE must lie within 0..MAX_VALUE");
  end

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         overflow_q;
  logic         overflow_d;
  logic [W-1:0] step_c;
  logic [W-1:0] load_c;
  logic [W:0]   sum_x;

  // The sum is kept one bit wider so an up-step past MAX_VALUE is seen before truncation.
  always_comb begin
    step_c     = (bus.step > MAX_W) ? MAX_W : bus.step;
    load_c     = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;
    sum_x      = {1'b0, count_q} + {1'b0, step_c};
    count_d    = count_q;
    overflow_d = 1'b0;
    if (bus.clear) begin
      count_d = RESET_W;
    end else if (bus.load) begin
      count_d = load_c;
    end else if (bus.enable) begin
      if (bus.up) begin
        if (sum_x > MAX_X) begin
          overflow_d = 1'b1;
          count_d    = (SATURATE != 0) ? MAX_W : W'(sum_x - MOD_X);
        end else begin
          count_d = sum_x[W-1:0];
        end
      end else begin
        if (step_c > count_q) begin
          overflow_d = 1'b1;
          count_d    = (SATURATE != 0) ? '0
                                       : W'({1'b0, count_q} + MOD_X - {1'b0, step_c});
        end else begin
          count_d = count_q - step_c;
        end
      end
    end
  end

`ifdef COUNTER_COMPARE_EN
  logic match_q;
  logic match_d;

  // Pulse only on entry: new value equal and old value not, against the same compare_value.
  always_comb begin
    match_d = (count_d == bus.compare_value) && (count_q != bus.compare_value);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign bus.match = match_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= RESET_W;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.at_max   = (count_q == MAX_W);
  assign bus.at_min   = (count_q == '0);
endmodule

// File: tb/tb_counter_updown_step.sv
// Bench for counter_updown_step: three instances (MAX 9 wrap, MAX 9 saturate,
// MAX 200 wrap with non-zero reset value) against an integer reference model.
module tb_counter_updown_step;
  localparam int MAX_S = 9;
  localparam int MAX_B = 200;
  localparam int RV_B  = 17;
  localparam int WS    = $clog2(MAX_S + 1);
  localparam int WB    = $clog2(MAX_B + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  counter_updown_step_if #(.W(WS)) if_w ();
  counter_updown_step_if #(.W(WS)) if_s ();
  counter_updown_step_if #(.W(WB)) if_b ();

  counter_updown_step #(.MAX_VALUE(MAX_S), .RESET_VALUE(0), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .bus(if_w.slave));
  counter_updown_step #(.MAX_VALUE(MAX_S), .RESET_VALUE(0), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave));
  counter_updown_step #(.MAX_VALUE(MAX_B), .RESET_VALUE(RV_B), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  typedef struct {
    bit clr;
    bit ld;
    bit en;
    bit up;
    int step;
    int lv;
    int cmp;
  } in_t;

  typedef struct {
    int d;
    bit clr;
    bit ld;
    bit en;
    bit up;
    int step;
    int lv;
    int e_cnt;
    bit e_ovf;
    bit e_amax;
    bit e_amin;
  } vec_t;

  in_t  cur [3];
  int   max_a [3];
  int   sat_a [3];
  int   rv_a  [3];
  int   wid_a [3];
  int   m_cnt [3];
  bit   m_ovf [3];
  bit   m_mt  [3];
  vec_t tbl [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d);
    case (d)
      0: begin
        if_w.clear = cur[0].clr; if_w.load = cur[0].ld; if_w.enable = cur[0].en;
        if_w.up = cur[0].up; if_w.step = WS'(cur[0].step); if_w.load_value = WS'(cur[0].lv);
`ifdef COUNTER_COMPARE_EN
        if_w.compare_value = WS'(cur[0].cmp);
`endif
      end
      1: begin
        if_s.clear = cur[1].clr; if_s.load = cur[1].ld; if_s.enable = cur[1].en;
        if_s.up = cur[1].up; if_s.step = WS'(cur[1].step); if_s.load_value = WS'(cur[1].lv);
`ifdef COUNTER_COMPARE_EN
        if_s.compare_value = WS'(cur[1].cmp);
`endif
      end
      default: begin
        if_b.clear = cur[2].clr; if_b.load = cur[2].ld; if_b.enable = cur[2].en;
        if_b.up = cur[2].up; if_b.step = WB'(cur[2].step); if_b.load_value = WB'(cur[2].lv);
`ifdef COUNTER_COMPARE_EN
        if_b.compare_value = WB'(cur[2].cmp);
`endif
      end
    endcase
  endtask

  task automatic set_in(input int d, input bit clr, input bit ld, input bit en,
                        input bit up, input int st, input int lv);
    cur[d].clr = clr; cur[d].ld = ld; cur[d].en = en;
    cur[d].up = up; cur[d].step = st; cur[d].lv = lv;
    drive(d);
  endtask

  task automatic set_cmp(input int d, input int v);
    cur[d].cmp = v;
    drive(d);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) set_in(d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_out(input int d, output int c, output bit ov, output bit amx,
                          output bit amn, output bit mt);
    mt = 1'b0;
    case (d)
      0: begin
        c = int'(if_w.count); ov = if_w.overflow; amx = if_w.at_max; amn = if_w.at_min;
`ifdef COUNTER_COMPARE_EN
        mt = if_w.match;
`endif
      end
      1: begin
        c = int'(if_s.count); ov = if_s.overflow; amx = if_s.at_max; amn = if_s.at_min;
`ifdef COUNTER_COMPARE_EN
        mt = if_s.match;
`endif
      end
      default: begin
        c = int'(if_b.count); ov = if_b.overflow; amx = if_b.at_max; amn = if_b.at_min;
`ifdef COUNTER_COMPARE_EN
        mt = if_b.match;
`endif
      end
    endcase
  endtask

  // Reference: plain signed integer arithmetic with modulo for wrap.
  task automatic model_step(input int d);
    int mx  = max_a[d];
    int old = m_cnt[d];
    int nx  = old;
    int s;
    int raw;
    bit ov  = 1'b0;
    if (cur[d].clr) begin
      nx = rv_a[d];
    end else if (cur[d].ld) begin
      nx = (cur[d].lv > mx) ? mx : cur[d].lv;
    end else if (cur[d].en) begin
      s   = (cur[d].step > mx) ? mx : cur[d].step;
      raw = cur[d].up ? old + s : old - s;
      if (raw > mx || raw < 0) begin
        ov = 1'b1;
        if (sat_a[d] != 0) nx = (raw > mx) ? mx : 0;
        else               nx = ((raw % (mx + 1)) + (mx + 1)) % (mx + 1);
      end else begin
        nx = raw;
      end
    end
    m_mt[d]  = (nx == cur[d].cmp) && (old != cur[d].cmp);
    m_cnt[d] = nx;
    m_ovf[d] = ov;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = rv_a[d];
      m_ovf[d] = 1'b0;
      m_mt[d]  = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    int c;
    bit ov, amx, amn, mt;
    for (int d = 0; d < 3; d++) begin
      read_out(d, c, ov, amx, amn, mt);
      chk($sformatf("%s.d%0d.count", tag, d), c, m_cnt[d]);
      chk($sformatf("%s.d%0d.overflow", tag, d), int'(ov), int'(m_ovf[d]));
      chk($sformatf("%s.d%0d.at_max", tag, d), int'(amx), int'(m_cnt[d] == max_a[d]));
      chk($sformatf("%s.d%0d.at_min", tag, d), int'(amn), int'(m_cnt[d] == 0));
`ifdef COUNTER_COMPARE_EN
      chk($sformatf("%s.d%0d.match", tag, d), int'(mt), int'(m_mt[d]));
`endif
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) model_step(d);
    check_model(tag);
  endtask

  task automatic add_vec(input int d, input bit clr, input bit ld, input bit en, input bit up,
                         input int st, input int lv, input int e_cnt, input bit e_ovf,
                         input bit e_amax, input bit e_amin);
    vec_t v;
    v.d = d; v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.step = st; v.lv = lv;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_amax = e_amax; v.e_amin = e_amin;
    tbl.push_back(v);
  endtask

  initial begin
    int c;
    bit ov, amx, amn, mt;

    max_a = '{MAX_S, MAX_S, MAX_B};
    sat_a = '{0, 1, 0};
    rv_a  = '{0, 0, RV_B};
    wid_a = '{WS, WS, WB};
    for (int d = 0; d < 3; d++) cur[d].cmp = (d == 2) ? 100 : 5;
    idle_all();
    model_reset();

    // Wrap, MAX 9: up by 3 from 0, clamps, priority, down wrap, load clamp.
    add_vec(0, 0, 0, 1, 1,  3,  0, 3, 0, 0, 0);
    add_vec(0, 0, 0, 1, 1,  3,  0, 6, 0, 0, 0);
    add_vec(0, 0, 0, 1, 1,  3,  0, 9, 0, 1, 0);
    add_vec(0, 0, 0, 1, 1,  3,  0, 2, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1,  3,  0, 5, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0,  0,  4, 4, 0, 0, 0);
    add_vec(0, 0, 0, 1, 1, 15,  0, 3, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1,  0,  0, 3, 0, 0, 0);
    add_vec(0, 1, 1, 1, 1,  1,  8, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0,  1,  0, 9, 1, 1, 0);
    add_vec(0, 0, 0, 1, 0,  9,  0, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0,  0, 12, 9, 0, 1, 0);
    // Saturate, MAX 9: down by 4 from 6, pinned bounds keep flagging.
    add_vec(1, 0, 1, 0, 0,  0,  6, 6, 0, 0, 0);
    add_vec(1, 0, 0, 1, 0,  4,  0, 2, 0, 0, 0);
    add_vec(1, 0, 0, 1, 0,  4,  0, 0, 1, 0, 1);
    add_vec(1, 0, 0, 1, 0,  4,  0, 0, 1, 0, 1);
    add_vec(1, 0, 0, 1, 0,  0,  0, 0, 0, 0, 1);
    add_vec(1, 0, 1, 0, 0,  0,  9, 9, 0, 1, 0);
    add_vec(1, 0, 0, 1, 1,  1,  0, 9, 1, 1, 0);
    add_vec(1, 0, 0, 1, 0, 15,  0, 0, 0, 0, 1);
    add_vec(1, 0, 0, 1, 1,  9,  0, 9, 0, 1, 0);
    // Wrap, MAX 200, reset value 17.
    add_vec(2, 1, 1, 1, 1,  5, 50, RV_B, 0, 0, 0);
    add_vec(2, 0, 1, 0, 0,  0, 250, 200, 0, 1, 0);
    add_vec(2, 0, 0, 1, 1,  1,  0, 0, 1, 0, 1);
    add_vec(2, 0, 0, 1, 0, 255, 0, 1, 1, 0, 0);
    add_vec(2, 0, 1, 0, 0,  0,  7, 7, 0, 0, 0);

    // Reset held across an edge, then released between edges.
    @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.b.count", int'(if_b.count), RV_B);
    #3;
    reset = 1'b1;

    foreach (tbl[i]) begin
      idle_all();
      set_in(tbl[i].d, tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].step, tbl[i].lv);
      tick("vec");
      read_out(tbl[i].d, c, ov, amx, amn, mt);
      chk($sformatf("vec%0d.count", i), c, tbl[i].e_cnt);
      chk($sformatf("vec%0d.overflow", i), int'(ov), int'(tbl[i].e_ovf));
      chk($sformatf("vec%0d.at_max", i), int'(amx), int'(tbl[i].e_amax));
      chk($sformatf("vec%0d.at_min", i), int'(amn), int'(tbl[i].e_amin));
    end

    // Asynchronous reset mid-cycle with dut_b at 7.
    idle_all();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset.b.count", int'(if_b.count), RV_B);
    chk("async_reset.w.count", int'(if_w.count), 0);
    check_model("async_reset");
    #2;
    reset = 1'b1;
    set_in(2, 0, 0, 1, 1, 1, 0);
    tick("post_reset");
    chk("post_reset.b.count", int'(if_b.count), RV_B + 1);

    // Compare entry on dut_w: pulses at 5, again after wrap, not while held.
    idle_all();
    set_cmp(0, 5);
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick("cmp_clear");
    for (int k = 1; k <= 15; k++) begin
      set_in(0, 0, 0, 1, 1, 1, 0);
      tick("cmp_up");
      chk($sformatf("cmp_up%0d.count", k), int'(if_w.count), k % 10);
`ifdef COUNTER_COMPARE_EN
      chk($sformatf("cmp_up%0d.match", k), int'(if_w.match), int'((k % 10) == 5));
`endif
    end
    idle_all();
    for (int k = 0; k < 3; k++) begin
      tick("cmp_hold");
`ifdef COUNTER_COMPARE_EN
      chk("cmp_hold.match", int'(if_w.match), 0);
`endif
    end
    set_cmp(0, 3);
    tick("cmp_move");
    set_cmp(0, 5);
    tick("cmp_back");
    chk("cmp_back.count", int'(if_w.count), 5);
`ifdef COUNTER_COMPARE_EN
    chk("cmp_back.match", int'(if_w.match), 0);
`endif

    // Randomized traffic on all three instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++) begin
        int top = (1 << wid_a[d]) - 1;
        int st  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, top));
        if ($urandom_range(0, 7) == 0) cur[d].cmp = int'($urandom_range(0, top));
        set_in(d, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               st, int'($urandom_range(0, top)));
      end
      tick("rand");
    end

    idle_all();
    tick("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
